// File: rtl/iob_fifo_burst_drain_pkg.sv
// Shared types and helpers for the burst drain block.
// State encodings and the internal length-counter width.
package iob_fifo_burst_drain_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StData = 2'd2
  } state_e;

  localparam int unsigned SkidDepth = 2;

  // Length counters must hold BURST_LEN itself, not just BURST_LEN-1.
  function automatic int unsigned len_width(input int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/iob_fifo_burst_drain_if.sv
// FIFO read port plus burst request/data channel of the burst drain block.
// master = the drain engine, slave = FIFO and memory-side write channel.
interface iob_fifo_burst_drain_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BURST_LEN = 8
);
  localparam int unsigned ReqLenW = $clog2(BURST_LEN);

  logic                fifo_r_en;
  logic [DATA_W-1:0]   fifo_r_data;
  logic                fifo_r_empty;
  logic [ADDR_W:0]     fifo_level;
  logic                req_valid;
  logic                req_ready;
  logic [ReqLenW-1:0]  req_len;
  logic                data_valid;
  logic                data_ready;
  logic [DATA_W-1:0]   data;
  logic                data_last;

  modport master (
    output fifo_r_en,
    input  fifo_r_data,
    input  fifo_r_empty,
    input  fifo_level,
    output req_valid,
    input  req_ready,
    output req_len,
    output data_valid,
    input  data_ready,
    output data,
    output data_last
  );

  modport slave (
    input  fifo_r_en,
    output fifo_r_data,
    output fifo_r_empty,
    output fifo_level,
    input  req_valid,
    output req_ready,
    input  req_len,
    input  data_valid,
    output data_ready,
    input  data,
    input  data_last
  );

endinterface

// File: rtl/iob_skid_buf2.sv
// Two-entry in-order buffer absorbing FIFO read data returned under backpressure.
module iob_skid_buf2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        occ_q, occ_d;
  logic              do_pop;

  assign do_pop = pop && (occ_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_data;
        else               ent1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; new data lands behind whatever remains.
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data = ent0_q;
  assign occ       = occ_q;

endmodule

// File: rtl/iob_fifo_burst_drain.sv
// Drains a sync FIFO into length-announced bursts (request, then len data beats).
// Optional idle timeout that forces partial bursts: define IOB_BURST_TIMEOUT_EN.
module iob_fifo_burst_drain
  import iob_fifo_burst_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  flush,
  output logic                  busy,
  iob_fifo_burst_drain_if.master bus
);

  localparam int unsigned LenW    = len_width(BURST_LEN);
  localparam int unsigned ReqLenW = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] BurstLevel = (ADDR_W+1)'(BURST_LEN);

  if (BURST_LEN < 2 || BURST_LEN > (1 << ADDR_W) || TIMEOUT < 1) begin : gen_bad_param
    $error("iob_fifo_burst_drain: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   rd_left_q, rd_left_d;
  logic [LenW-1:0]   wr_left_q, wr_left_d;
  logic              inflight_q;
  logic              rd_en;
  logic              pop;
  logic              tmo_fire;
  logic              level_nz;
  logic [1:0]        occ;
  logic [2:0]        ahead;
  logic [DATA_W-1:0] head_data;

  assign level_nz = (bus.fifo_level != '0);
  assign pop      = bus.data_valid && bus.data_ready;
  // Beats already fetched but not yet consumed once this cycle's pop retires.
  assign ahead    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    rd_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.fifo_level >= BurstLevel) begin
          len_d   = LenW'(BURST_LEN);
          state_d = StReq;
        end else if ((flush || tmo_fire) && level_nz) begin
          len_d   = LenW'(bus.fifo_level);
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.req_ready) begin
          rd_left_d = len_q;
          wr_left_d = len_q;
          state_d   = StData;
        end
      end
      StData: begin
        rd_en = (rd_left_q != '0) && !bus.fifo_r_empty && (ahead < 3'd2);
        if (rd_en) rd_left_d = rd_left_q - LenW'(1);
        if (pop) begin
          wr_left_d = wr_left_q - LenW'(1);
          if (wr_left_q == LenW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      inflight_q <= rd_en;
    end
  end

`ifdef IOB_BURST_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts only while a partial burst sits waiting; any exit from idle restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == StIdle && state_d == StIdle && level_nz && bus.fifo_level < BurstLevel) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end

  assign tmo_fire = (tmo_q == TmoW'(TIMEOUT - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  iob_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (inflight_q),
    .push_data (bus.fifo_r_data),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign busy           = (state_q != StIdle);
  assign bus.fifo_r_en  = rd_en;
  assign bus.req_valid  = (state_q == StReq);
  assign bus.req_len    = (state_q == StReq) ? ReqLenW'(len_q - LenW'(1)) : '0;
  assign bus.data_valid = (occ != 2'd0);
  assign bus.data       = bus.data_valid ? head_data : '0;
  assign bus.data_last  = bus.data_valid && (wr_left_q == LenW'(1));

endmodule

// File: tb/tb_iob_fifo_burst_drain.sv
// Bench for iob_fifo_burst_drain: behavioural FIFO, cycle tables and burst sequences.
module tb_iob_fifo_burst_drain;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        fifo_rst_n;
  logic        flush;
  logic        busy;
  logic        wr_en;
  logic [31:0] wr_data;

  logic [31:0] mem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  lvl;

  int n_checks = 0;
  int n_errors = 0;
  int n_fetch, n_pop, n_last, max_ahead, gap;
  logic [32:0] beats [$];
  logic [2:0]  reqs [$];

  typedef struct packed {
    logic        flush;
    logic        rr;
    logic        dr;
    logic        busy;
    logic        rv;
    logic [2:0]  len;
    logic        ren;
    logic        dv;
    logic        last;
    logic [31:0] data;
  } row_t;

  row_t tab1 [17];
  row_t tab2 [11];

  iob_fifo_burst_drain_if #(.DATA_W(32), .ADDR_W(4), .BURST_LEN(8)) bus ();

  iob_fifo_burst_drain #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .BURST_LEN (8),
    .TIMEOUT   (16)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .flush  (flush),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Sync FIFO stand-in: registered read data, one cycle after fifo_r_en.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!fifo_rst_n) begin
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      bus.fifo_r_data <= '0;
    end else begin
      if (wr_en) wp <= wp + 4'd1;
      if (bus.fifo_r_en) begin
        bus.fifo_r_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      lvl <= lvl + 5'(wr_en) - 5'(bus.fifo_r_en);
    end
  end

  assign bus.fifo_level   = lvl;
  assign bus.fifo_r_empty = (lvl == 5'd0);

  function automatic row_t mk(input logic fl, input logic rr, input logic dr, input logic bz,
                              input logic rv, input logic [2:0] len, input logic ren,
                              input logic dv, input logic last, input logic [31:0] data);
    row_t r;
    r.flush = fl; r.rr = rr; r.dr = dr; r.busy = bz; r.rv = rv; r.len = len;
    r.ren = ren; r.dv = dv; r.last = last; r.data = data;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    reqs.delete();
    n_fetch = 0; n_pop = 0; n_last = 0; max_ahead = 0; gap = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    if (bus.req_valid && bus.req_ready) reqs.push_back(bus.req_len);
    if (bus.data_valid && bus.data_ready) begin
      beats.push_back({bus.data_last, bus.data});
      n_pop++;
      if (bus.data_last) n_last++;
    end
    if (bus.fifo_r_en) n_fetch++;
    if (n_fetch - n_pop > max_ahead) max_ahead = n_fetch - n_pop;
    if (!busy && n_last == 1) gap++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 32'(i);
      sample();
      advance();
    end
    wr_en = 1'b0;
  endtask

  task automatic apply_row(input string name, input int idx, input row_t r);
    flush = r.flush;
    bus.req_ready = r.rr;
    bus.data_ready = r.dr;
    sample();
    check($sformatf("%s row%0d", name, idx),
          {24'b0, busy, bus.req_valid, r.rv ? bus.req_len : 3'd0, bus.fifo_r_en,
           bus.data_valid, bus.data_last, r.dv ? bus.data : 32'd0},
          {24'b0, r.busy, r.rv, r.len, r.ren, r.dv, r.last, r.data});
    advance();
  endtask

  task automatic run_seq(input string name, input int n_wr, input logic [31:0] wr_base,
                         input bit hold_flush, input bit toggle, input int exp_beats,
                         input logic [31:0] beat_base, input logic [31:0] last_mask,
                         input int n_req, input logic [11:0] exp_reqs);
    int c = 0;
    bus.req_ready = 1'b1;
    while (c < 200 && !(c > n_wr && beats.size() == exp_beats && !busy)) begin
      wr_en = (c < n_wr);
      wr_data = wr_base + 32'(c);
      flush = hold_flush;
      bus.data_ready = toggle ? c[0] : 1'b1;
      sample();
      advance();
      c++;
    end
    wr_en = 1'b0;
    flush = 1'b0;
    bus.data_ready = 1'b1;
    check({name, " timeout"}, 64'(c >= 200), 64'd0);
    check({name, " beat count"}, 64'(beats.size()), 64'(exp_beats));
    for (int i = 0; i < exp_beats && i < beats.size(); i++) begin
      check($sformatf("%s beat%0d", name, i), 64'(beats[i]),
            {31'b0, last_mask[i], beat_base + 32'(i)});
    end
    check({name, " req count"}, 64'(reqs.size()), 64'(n_req));
    for (int k = 0; k < n_req && k < reqs.size(); k++) begin
      check($sformatf("%s req_len%0d", name, k), 64'(reqs[k]), 64'(exp_reqs[3*k +: 3]));
    end
    check({name, " max ahead"}, 64'(max_ahead), 64'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    arst_n = 1'b0; fifo_rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    bus.req_ready = 1'b0; bus.data_ready = 1'b0;
    clear_mon();

    // Stall 5 cycles in REQ, then a full burst of A0..A7 at one beat per cycle.
    for (int i = 0; i < 5; i++) tab1[i] = mk(0, 0, 1, 1, 1, 3'd7, 0, 0, 0, 0);
    tab1[5] = mk(0, 1, 1, 1, 1, 3'd7, 0, 0, 0, 0);
    tab1[6] = mk(0, 1, 1, 1, 0, 3'd0, 1, 0, 0, 0);
    tab1[7] = mk(0, 1, 1, 1, 0, 3'd0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tab1[8+i] = mk(0, 1, 1, 1, 0, 3'd0, 1, 1, 0, 32'hA0 + 32'(i));
    tab1[14] = mk(0, 1, 1, 1, 0, 3'd0, 0, 1, 0, 32'hA6);
    tab1[15] = mk(0, 1, 1, 1, 0, 3'd0, 0, 1, 1, 32'hA7);
    tab1[16] = mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);

    // Flush of 3 words, then flush with an empty FIFO.
    tab2[0]  = mk(1, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);
    tab2[1]  = mk(0, 1, 1, 1, 1, 3'd2, 0, 0, 0, 0);
    tab2[2]  = mk(0, 1, 1, 1, 0, 3'd0, 1, 0, 0, 0);
    tab2[3]  = mk(0, 1, 1, 1, 0, 3'd0, 1, 0, 0, 0);
    tab2[4]  = mk(0, 1, 1, 1, 0, 3'd0, 1, 1, 0, 32'hB0);
    tab2[5]  = mk(0, 1, 1, 1, 0, 3'd0, 0, 1, 0, 32'hB1);
    tab2[6]  = mk(0, 1, 1, 1, 0, 3'd0, 0, 1, 1, 32'hB2);
    tab2[7]  = mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);
    tab2[8]  = mk(1, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);
    tab2[9]  = mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);
    tab2[10] = mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    sample();
    check("reset outputs",
          {24'b0, busy, bus.req_valid, bus.req_len, bus.fifo_r_en, bus.data_valid,
           bus.data_last, bus.data}, 64'd0);
    advance();
    arst_n = 1'b1;
    fifo_rst_n = 1'b1;

    write_words(8, 32'hA0);
    sample(); advance();
    sample(); advance();
    for (int i = 0; i < 17; i++) apply_row("stall_full", i, tab1[i]);

    write_words(3, 32'hB0);
    sample(); advance();
    sample(); advance();
    for (int i = 0; i < 11; i++) apply_row("flush3", i, tab2[i]);

    clear_mon();
    run_seq("toggle", 8, 32'hC0, 1'b0, 1'b1, 8, 32'hC0, 32'h80, 1, 12'o7);

    clear_mon();
    run_seq("b2b", 16, 32'hD0, 1'b0, 1'b0, 16, 32'hD0, 32'h8080, 2, 12'o77);
    check("b2b idle gap", 64'(gap), 64'd1);
    check("b2b level", 64'(bus.fifo_level), 64'd0);

    // Level 9 in idle with flush high: full burst wins, remainder goes out as len 1.
    bus.req_ready = 1'b0;
    write_words(12, 32'h100);
    clear_mon();
    run_seq("priority", 5, 32'h10C, 1'b1, 1'b0, 17, 32'h100, 32'h18080, 3, 12'o077);

    // Reset after the third beat of a burst.
    bus.req_ready = 1'b0;
    write_words(8, 32'h50);
    clear_mon();
    bus.req_ready = 1'b1;
    bus.data_ready = 1'b1;
    for (int i = 0; i < 30 && beats.size() < 3; i++) begin
      sample();
      advance();
    end
    check("midburst beats before reset", 64'(beats.size()), 64'd3);
    arst_n = 1'b0;
    #1;
    check("midburst reset outputs",
          {24'b0, busy, bus.req_valid, bus.req_len, bus.fifo_r_en, bus.data_valid,
           bus.data_last, bus.data}, 64'd0);
    advance();
    advance();
    arst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (busy || bus.req_valid || bus.fifo_r_en) bad++;
      advance();
    end
    check("post reset quiet", 64'(bad), 64'd0);
    check("post reset level", 64'(bus.fifo_level), 64'd3);
    clear_mon();
    run_seq("post reset flush", 0, 32'h0, 1'b1, 1'b0, 3, 32'h55, 32'h4, 1, 12'o2);

    // Two words left sitting in the FIFO with no flush.
    clear_mon();
    bus.req_ready = 1'b1;
    bus.data_ready = 1'b1;
    write_words(2, 32'h60);
    for (int i = 0; i < 24; i++) begin
      sample();
      advance();
    end
`ifdef IOB_BURST_TIMEOUT_EN
    check("timeout req count", 64'(reqs.size()), 64'd1);
    if (reqs.size() > 0) check("timeout req_len", 64'(reqs[0]), 64'd1);
    check("timeout beats", 64'(beats.size()), 64'd2);
`else
    check("no timeout req", 64'(reqs.size()), 64'd0);
    check("no timeout beats", 64'(beats.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
